pzcorebus_dummy_master: RTL
===========================

PZCOREBUS_DUMMY_MASTER -- requirements
Module: pzcorebus_dummy_master

Interface
REQ-001 SHALL have parameter BUS_CONFIG, default pzcorebus_pkg default config, bus profile/widths of master_if.
REQ-002 SHALL have parameter COUNT_WIDTH, default 8, width of packet/beat counters (range 1..32).
REQ-003 SHALL have parameter STOP_ON_ERROR, default 1, 1 = deassert sresp_accept once error latched; 0 = keep sinking.
REQ-004 SHALL have port i_clk  input  1  clock.
REQ-005 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port i_clear  input  1  synchronous clear of counters, captures, error.
REQ-007 SHALL have port master_if  interface  pzcorebus_if.master  full master side (request + response).
REQ-008 SHALL have port o_error  output  1  sticky: any response received.
REQ-009 SHALL have port o_packet_count  output  COUNT_WIDTH  saturating count of completed response packets.
REQ-010 SHALL have port o_beat_count  output  COUNT_WIDTH  saturating count of accepted response beats.
REQ-011 SHALL have port o_first_sid  output  BUS_CONFIG id width  sid of first accepted beat after reset/clear.
REQ-012 SHALL have port o_first_sresp  output  pzcorebus_response_type  sresp of first accepted beat.

Function
REQ-013 SHALL drive request channel constant: mcmd_valid=0, mcmd=PZCOREBUS_NULL_COMMAND, mid/maddr/mlength/minfo=0, mdata_valid=0, mdata/mdata_byteen/mdata_last=0, in every cycle including reset.
REQ-014 SHALL drive sresp_accept=1 in IDLE and BURST; in ERROR, sresp_accept = !STOP_ON_ERROR.
REQ-015 SHALL define beat accept as sresp_valid && sresp_accept at rising i_clk.
REQ-016 SHALL define packet end as accepted beat with sresp_last=1, or sresp type without data (non-read response) regardless of sresp_last.
REQ-017 SHALL implement FSM IDLE, BURST, ERROR; reset state IDLE.
REQ-018 IDLE: accepted beat that is packet end -> ERROR; accepted beat not packet end -> BURST; else stay.
REQ-019 BURST: accepted beat with packet end -> ERROR; otherwise stay in BURST.
REQ-020 ERROR: stay until i_clear; i_clear -> IDLE.
REQ-021 o_error SHALL rise the cycle after the first accepted beat (1-cycle latency) and hold until i_clear or reset.
REQ-022 o_first_sid/o_first_sresp SHALL capture only on first accepted beat after reset/clear; later beats do not overwrite.
REQ-023 o_beat_count +1 per accepted beat, o_packet_count +1 per packet end; both saturate at all-ones, no wrap.
REQ-024 i_clear coincident with accepted beat: clear wins, beat not counted, not captured, FSM -> IDLE.
REQ-025 Request-side outputs SHALL never depend on FSM state or response inputs.

Reset
REQ-026 On i_rst_n=0 asynchronously: FSM=IDLE, o_error=0, both counts=0, o_first_sid=0, o_first_sresp=0 (PZCOREBUS_RESPONSE_NULL equivalent encoding 0).
REQ-027 Reset mid-burst SHALL discard partial packet; first beat after release counts as new first beat.

Configuration
REQ-028 Macro PZCOREBUS_DUMMY_MASTER_MONITOR_EN: defined -> FSM, counters, captures, o_error as specified.
REQ-029 Not defined -> no monitor flops; sresp_accept=1 always; o_error, counts, captures tied to 0; request tie-off unchanged.

Structure
REQ-030 pzcorebus_pkg SHALL hold pzcorebus_config, PZCOREBUS_NULL_COMMAND, pzcorebus_response_type and the no-data-response test function; FSM state enum local to module.
REQ-031 Monitor SHALL be sub-module pzcorebus_dummy_master_response_monitor (FSM, counters, captures), instantiated only under PZCOREBUS_DUMMY_MASTER_MONITOR_EN.

Verification
REQ-032 Idle 100 cycles after reset -> mcmd_valid=0, mdata_valid=0, mcmd=NULL every cycle; o_error=0, counts=0.
REQ-033 One write response sid=0x5 -> next cycle o_error=1, o_packet_count=1, o_beat_count=1, o_first_sid=0x5; STOP_ON_ERROR=1 -> sresp_accept=0.
REQ-034 STOP_ON_ERROR=0, 4-beat read response sid=0x3 then 1-beat sid=0x7 -> beat_count=5, packet_count=2, first_sid=0x3.
REQ-035 COUNT_WIDTH=2, STOP_ON_ERROR=0, 6 single-beat responses -> both counts saturate at 3.
REQ-036 i_clear asserted same cycle as an accepted beat -> counts stay 0, o_error=0, FSM IDLE next cycle.
REQ-037 i_rst_n dropped after beat 2 of 4-beat read -> outputs 0 immediately; post-release beat counted as first, first_sid updated.

Source files
------------

// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types: bus configuration, command/response encodings and
// the helper that tells whether a response type carries data.
package pzcorebus_pkg;

    typedef struct packed {
        int unsigned id_width;
        int unsigned address_width;
        int unsigned data_width;
        int unsigned length_width;
        int unsigned request_info_width;
    } pzcorebus_config;

    localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
        id_width:           8,
        address_width:      32,
        data_width:         32,
        length_width:       8,
        request_info_width: 2
    };

    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND      = 3'b000,
        PZCOREBUS_WRITE             = 3'b001,
        PZCOREBUS_READ              = 3'b010,
        PZCOREBUS_WRITE_NON_POSTED  = 3'b011,
        PZCOREBUS_MESSAGE           = 3'b100
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        PZCOREBUS_RESPONSE_NULL      = 2'b00,
        PZCOREBUS_RESPONSE           = 2'b01,
        PZCOREBUS_RESPONSE_WITH_DATA = 2'b10
    } pzcorebus_response_type;

    // Any response other than read data ends its packet on a single beat.
    function automatic logic pzcorebus_is_response_with_no_data(input pzcorebus_response_type sresp);
        return sresp != PZCOREBUS_RESPONSE_WITH_DATA;
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus request/response channel bundle with master and slave views.
interface pzcorebus_if #(
    parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG = pzcorebus_pkg::PZCOREBUS_DEFAULT_CONFIG
);
    import pzcorebus_pkg::*;

    localparam int unsigned ID_WIDTH     = BUS_CONFIG.id_width;
    localparam int unsigned ADDR_WIDTH   = BUS_CONFIG.address_width;
    localparam int unsigned DATA_WIDTH   = BUS_CONFIG.data_width;
    localparam int unsigned LEN_WIDTH    = BUS_CONFIG.length_width;
    localparam int unsigned INFO_WIDTH   = BUS_CONFIG.request_info_width;
    localparam int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8;

    logic                        mcmd_valid;
    logic                        mcmd_accept;
    pzcorebus_command_type       mcmd;
    logic [ID_WIDTH-1:0]         mid;
    logic [ADDR_WIDTH-1:0]       maddr;
    logic [LEN_WIDTH-1:0]        mlength;
    logic [INFO_WIDTH-1:0]       minfo;
    logic                        mdata_valid;
    logic                        mdata_accept;
    logic [DATA_WIDTH-1:0]       mdata;
    logic [BYTEEN_WIDTH-1:0]     mdata_byteen;
    logic                        mdata_last;
    logic                        sresp_valid;
    logic                        sresp_accept;
    pzcorebus_response_type      sresp;
    logic [ID_WIDTH-1:0]         sid;
    logic                        serror;
    logic [DATA_WIDTH-1:0]       sdata;
    logic                        sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        output mdata_valid, mdata, mdata_byteen, mdata_last,
        output sresp_accept,
        input  mcmd_accept, mdata_accept,
        input  sresp_valid, sresp, sid, serror, sdata, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        input  mdata_valid, mdata, mdata_byteen, mdata_last,
        input  sresp_accept,
        output mcmd_accept, mdata_accept,
        output sresp_valid, sresp, sid, serror, sdata, sresp_last
    );

endinterface

// File: rtl/pzcorebus_dummy_master_response_monitor.sv
// Response-side monitor for the dummy master: tracks packets, counts beats and
// packets with saturation, captures the first beat and flags any response.
module pzcorebus_dummy_master_response_monitor #(
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned STOP_ON_ERROR = 1
)(
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_clear,
    input  logic                                  i_sresp_valid,
    input  pzcorebus_pkg::pzcorebus_response_type i_sresp,
    input  logic [ID_WIDTH-1:0]                   i_sid,
    input  logic                                  i_sresp_last,
    output logic                                  o_sresp_accept,
    output logic                                  o_error,
    output logic [COUNT_WIDTH-1:0]                o_packet_count,
    output logic [COUNT_WIDTH-1:0]                o_beat_count,
    output logic [ID_WIDTH-1:0]                   o_first_sid,
    output pzcorebus_pkg::pzcorebus_response_type o_first_sresp
);
    import pzcorebus_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ERROR = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   error_q, error_d;
    logic [COUNT_WIDTH-1:0] packet_count_q, packet_count_d;
    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [ID_WIDTH-1:0]    first_sid_q, first_sid_d;
    pzcorebus_response_type first_sresp_q, first_sresp_d;
    logic                   accept;
    logic                   beat;
    logic                   packet_end;

    always_comb begin
        accept         = (state_q != ERROR) || (STOP_ON_ERROR == 0);
        beat           = i_sresp_valid && accept;
        packet_end     = beat && (i_sresp_last || pzcorebus_is_response_with_no_data(i_sresp));
        state_d        = state_q;
        error_d        = error_q;
        packet_count_d = packet_count_q;
        beat_count_d   = beat_count_q;
        first_sid_d    = first_sid_q;
        first_sresp_d  = first_sresp_q;

        case (state_q)
            IDLE:    if (beat) state_d = packet_end ? ERROR : BURST;
            BURST:   if (packet_end) state_d = ERROR;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

        // error_q doubles as the "first beat already captured" flag.
        if (beat && !error_q) begin
            first_sid_d   = i_sid;
            first_sresp_d = i_sresp;
        end
        if (beat) error_d = 1'b1;
        if (beat && (beat_count_q != '1)) beat_count_d = beat_count_q + 1'b1;
        if (packet_end && (packet_count_q != '1)) packet_count_d = packet_count_q + 1'b1;

        if (i_clear) begin
            state_d        = IDLE;
            error_d        = 1'b0;
            packet_count_d = '0;
            beat_count_d   = '0;
            first_sid_d    = '0;
            first_sresp_d  = PZCOREBUS_RESPONSE_NULL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            error_q        <= 1'b0;
            packet_count_q <= '0;
            beat_count_q   <= '0;
            first_sid_q    <= '0;
            first_sresp_q  <= PZCOREBUS_RESPONSE_NULL;
        end else begin
            state_q        <= state_d;
            error_q        <= error_d;
            packet_count_q <= packet_count_d;
            beat_count_q   <= beat_count_d;
            first_sid_q    <= first_sid_d;
            first_sresp_q  <= first_sresp_d;
        end
    end

    assign o_sresp_accept = accept;
    assign o_error        = error_q;
    assign o_packet_count = packet_count_q;
    assign o_beat_count   = beat_count_q;
    assign o_first_sid    = first_sid_q;
    assign o_first_sresp  = first_sresp_q;

endmodule

// File: rtl/pzcorebus_dummy_master.sv
// Dummy pzcorebus master: request channel tied idle; response monitor present
// only when PZCOREBUS_DUMMY_MASTER_MONITOR_EN is defined, else responses are sunk.
module pzcorebus_dummy_master #(
    parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG = pzcorebus_pkg::PZCOREBUS_DEFAULT_CONFIG,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned STOP_ON_ERROR = 1
)(
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_clear,
    pzcorebus_if.master                           master_if,
    output logic                                  o_error,
    output logic [COUNT_WIDTH-1:0]                o_packet_count,
    output logic [COUNT_WIDTH-1:0]                o_beat_count,
    output logic [BUS_CONFIG.id_width-1:0]        o_first_sid,
    output pzcorebus_pkg::pzcorebus_response_type o_first_sresp
);
    import pzcorebus_pkg::*;

    logic unused_request_side;

    assign master_if.mcmd_valid   = 1'b0;
    assign master_if.mcmd         = PZCOREBUS_NULL_COMMAND;
    assign master_if.mid          = '0;
    assign master_if.maddr        = '0;
    assign master_if.mlength      = '0;
    assign master_if.minfo        = '0;
    assign master_if.mdata_valid  = 1'b0;
    assign master_if.mdata        = '0;
    assign master_if.mdata_byteen = '0;
    assign master_if.mdata_last   = 1'b0;

    assign unused_request_side = &{1'b0, master_if.mcmd_accept, master_if.mdata_accept,
                                   master_if.serror, master_if.sdata};

`ifdef PZCOREBUS_DUMMY_MASTER_MONITOR_EN
    pzcorebus_dummy_master_response_monitor #(
        .ID_WIDTH      (BUS_CONFIG.id_width),
        .COUNT_WIDTH   (COUNT_WIDTH),
        .STOP_ON_ERROR (STOP_ON_ERROR)
    ) u_monitor (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_clear        (i_clear),
        .i_sresp_valid  (master_if.sresp_valid),
        .i_sresp        (master_if.sresp),
        .i_sid          (master_if.sid),
        .i_sresp_last   (master_if.sresp_last),
        .o_sresp_accept (master_if.sresp_accept),
        .o_error        (o_error),
        .o_packet_count (o_packet_count),
        .o_beat_count   (o_beat_count),
        .o_first_sid    (o_first_sid),
        .o_first_sresp  (o_first_sresp)
    );
`else
    logic unused_monitor_inputs;

    assign master_if.sresp_accept = 1'b1;
    assign o_error                = 1'b0;
    assign o_packet_count         = '0;
    assign o_beat_count           = '0;
    assign o_first_sid            = '0;
    assign o_first_sresp          = PZCOREBUS_RESPONSE_NULL;
    assign unused_monitor_inputs  = &{1'b0, i_clk, i_rst_n, i_clear, master_if.sresp_valid,
                                      master_if.sresp, master_if.sid, master_if.sresp_last};
`endif

endmodule
